line_memory: RTL and testbench

- Multi-cycle main-memory model sitting directly downstream of the data cache inside mem_stage.
- Services whole-line refills (reads) and write-backs (writes) of 128-bit lines.
- Has a fixed, parameterised access latency and a single-outstanding valid/ready request port.
- Storage is an internal array named memArray (LINE_W bits x DEPTH entries), preloaded hierarchically by benches; it has no reset.

---
 rtl/line_memory.sv | 97 +++++++++
 tb/tb_line_memory.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory.sv
// line_memory: fixed-latency, single-outstanding line memory model behind the data cache.
// Define LINE_MEMORY_PERF_CNT_EN to add the rd_count/wr_count completion counters.
module line_memory #(
   parameter int LINE_W  = 128,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [LINE_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [LINE_W-1:0] resp_rdata,
   output logic              busy
`ifdef LINE_MEMORY_PERF_CNT_EN
   ,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [LINE_W-1:0] memArray [DEPTH];
   logic [1:0]        r_state;
   logic [7:0]        r_cnt;
   logic              r_write;
   logic [AW-1:0]     r_idx;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_rdata;
   logic              w_commit;
   logic              w_unused;

   // Only the line-index field of the byte address selects a line.
   assign w_unused   = ^{req_addr[31:4+AW], req_addr[3:0]};
   assign w_commit   = (r_state == S_BUSY) && (r_cnt == 8'd0);
   assign req_ready  = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else if (r_state == S_IDLE) begin
         if (req_valid) begin
            r_write <= req_write;
            r_idx   <= req_addr[4 +: AW];
            r_wdata <= req_wdata;
            r_cnt   <= 8'(LATENCY - 1);
            r_state <= S_BUSY;
         end
      end else if (r_state == S_BUSY) begin
         if (r_cnt == 8'd0) begin
            if (!r_write) r_rdata <= memArray[r_idx];
            r_state <= S_RESP;
         end else begin
            r_cnt <= r_cnt - 8'd1;
         end
      end else begin
         r_state <= S_IDLE;
      end
   end

   // Storage is never reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clock) begin
      if (!reset && w_commit && r_write) memArray[r_idx] <= r_wdata;
   end

`ifdef LINE_MEMORY_PERF_CNT_EN
   logic [31:0] r_rd_count;
   logic [31:0] r_wr_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_count <= 32'd0;
         r_wr_count <= 32'd0;
      end else if (w_commit) begin
         r_rd_count <= r_write ? r_rd_count : r_rd_count + 32'd1;
         r_wr_count <= r_write ? r_wr_count + 32'd1 : r_wr_count;
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`endif
endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: randomized self-checking bench for line_memory against a transaction-level model.
// Builds with or without LINE_MEMORY_PERF_CNT_EN.
module tb_line_memory;
   localparam int LW  = 128;
   localparam int DEP = 1024;
   localparam int LAT = 5;
   localparam logic [LW-1:0] L0 = 128'h0000AAAA_0000BBBB_0000CCCC_0000DDDD;
   localparam logic [LW-1:0] L3 = 128'h00000003_00000002_00000001_00000000;
   localparam logic [LW-1:0] L7 = 128'h77777777_66666666_55555555_44444444;
   localparam logic [LW-1:0] LW4 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [31:0]   req_addr = 32'd0;
   logic [LW-1:0] req_wdata = '0;
   logic          resp_valid;
   logic [LW-1:0] resp_rdata;
   logic          busy;
`ifdef LINE_MEMORY_PERF_CNT_EN
   logic [31:0]   rd_count;
   logic [31:0]   wr_count;
`endif

   line_memory #(.LINE_W(LW), .DEPTH(DEP), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
`ifdef LINE_MEMORY_PERF_CNT_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_fail = 0;
   bit armed = 1'b0;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Transaction-level model: a request accepted at edge a completes at edge a+LAT
   // and the port is free again after edge a+LAT+1.
   int            m_e = 0;
   int            m_acc = -1;
   bit            m_w;
   int            m_idx;
   logic [LW-1:0] m_wd;
   logic [LW-1:0] m_mem [DEP];
   bit            m_known [DEP];
   logic [LW-1:0] m_rd = '0;
   bit            m_rdk = 1'b1;
   logic [31:0]   m_rc = 0;
   logic [31:0]   m_wc = 0;

   always @(posedge clock) begin
      m_e++;
      if (reset) begin
         m_acc = -1;
         m_rd  = '0;
         m_rdk = 1'b1;
         m_rc  = 0;
         m_wc  = 0;
      end else if (m_acc >= 0 && m_e == m_acc + LAT) begin
         if (m_w) begin
            m_mem[m_idx] = m_wd;
            m_known[m_idx] = 1'b1;
            m_wc++;
         end else begin
            m_rd  = m_mem[m_idx];
            m_rdk = m_known[m_idx];
            m_rc++;
         end
      end else if ((m_acc < 0 || m_e - 1 >= m_acc + LAT + 1) && req_valid) begin
         m_acc = m_e;
         m_w   = req_write;
         m_idx = int'((req_addr >> 4) % DEP);
         m_wd  = req_wdata;
      end
   end

   always @(negedge clock) begin
      if (armed) begin
         automatic bit b = (m_acc >= 0) && (m_e <= m_acc + LAT);
         chk("busy", LW'(busy), LW'(b));
         chk("req_ready", LW'(req_ready), LW'(!b));
         chk("resp_valid", LW'(resp_valid), LW'((m_acc >= 0) && (m_e == m_acc + LAT)));
         if (m_rdk) chk("resp_rdata", resp_rdata, m_rd);
`ifdef LINE_MEMORY_PERF_CNT_EN
         chk("rd_count", LW'(rd_count), LW'(m_rc));
         chk("wr_count", LW'(wr_count), LW'(m_wc));
`endif
      end
   end

   task automatic xfer(input bit w, input logic [31:0] a, input logic [LW-1:0] d,
                       output logic [LW-1:0] rd, output int lat);
      int t;
      int acc;
      @(negedge clock);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      t = 0;
      while (!req_ready && t < 100) begin @(negedge clock); t++; end
      if (!req_ready) chk("accept_timeout", LW'(req_ready), LW'(1));
      @(negedge clock);
      acc = m_e;
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      t = 0;
      while (!resp_valid && t < 300) begin @(negedge clock); t++; end
      if (!resp_valid) chk("resp_timeout", LW'(resp_valid), LW'(1));
      rd = resp_rdata;
      lat = m_e - acc;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 300) begin @(negedge clock); t++; end
      if (busy) chk("idle_timeout", LW'(busy), LW'(0));
   endtask

   initial begin
      logic [LW-1:0] rd;
      logic [LW-1:0] line;
      int lat;
      int last;
      int n_acc;
      int t;
      bit w;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      armed = 1'b1;
      chk("reset_rdata", resp_rdata, '0);
      chk("reset_ready", LW'(req_ready), LW'(1));
      chk("reset_resp_valid", LW'(resp_valid), LW'(0));

      for (int i = 0; i < 8; i++) begin
         line = (i == 0) ? L0 : (i == 3) ? L3 : (i == 7) ? L7 : {$urandom, $urandom, $urandom, $urandom};
         xfer(1'b1, 32'(i * 16), line, rd, lat);
      end

      xfer(1'b0, 32'h30, '0, rd, lat);
      chk("read_line3", rd, L3);
      chk("read_latency", LW'(lat), LW'(5));
      chk("busy_in_resp", LW'(busy), LW'(1));
      @(negedge clock);
      chk("busy_after_resp", LW'(busy), LW'(0));

      xfer(1'b1, 32'h40, LW4, rd, lat);
      chk("write_keeps_rdata", rd, L3);
      chk("write_latency", LW'(lat), LW'(5));
      xfer(1'b0, 32'h40, '0, rd, lat);
      chk("read_after_write", rd, LW4);

      xfer(1'b0, 32'h4000, '0, rd, lat);
      chk("alias_4000", rd, L0);
      xfer(1'b0, 32'h0000000C, '0, rd, lat);
      chk("low_bits_0c", rd, L0);

      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h70; req_wdata = ~L7;
      t = 0;
      while (!req_ready && t < 100) begin @(negedge clock); t++; end
      @(negedge clock);
      req_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_ready", LW'(req_ready), LW'(1));
      chk("abort_busy", LW'(busy), LW'(0));
      chk("abort_rdata", resp_rdata, '0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("abort_no_resp", LW'(resp_valid), LW'(0));
      end
      xfer(1'b0, 32'h70, '0, rd, lat);
      chk("abort_line7_kept", rd, L7);

      xfer(1'b0, 32'h30, '0, rd, lat);
      xfer(1'b0, 32'h40, '0, rd, lat);
      chk("reread_line4", rd, LW4);
      xfer(1'b1, 32'h50, {4{$urandom}}, rd, lat);
      xfer(1'b1, 32'h60, {4{$urandom}}, rd, lat);
`ifdef LINE_MEMORY_PERF_CNT_EN
      chk("perf_rd_count", LW'(rd_count), LW'(3));
      chk("perf_wr_count", LW'(wr_count), LW'(2));
`endif
      wait_idle();

      // Continuously held requests must be accepted every LAT+2 edges.
      last = -1; n_acc = 0; t = 0; w = 1'b0;
      @(negedge clock);
      req_valid = 1'b1; req_write = w; req_addr = 32'($urandom_range(0, 7) * 16);
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      while (n_acc < 30 && t < 400) begin
         if (req_ready) begin
            @(negedge clock);
            if (last >= 0) chk("b2b_spacing", LW'(m_e - last), LW'(LAT + 2));
            last = m_e;
            n_acc++;
            w = !w;
            req_write = w; req_addr = ($urandom & 32'hFFFF_C00F) | 32'($urandom_range(0, 7) * 16);
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            @(negedge clock);
         end
         t++;
      end
      chk("b2b_accepts", LW'(n_acc), LW'(30));
      req_valid = 1'b0;
      wait_idle();

      for (int i = 0; i < 1500; i++) begin
         @(negedge clock);
         reset = ($urandom_range(0, 199) == 0);
         req_valid = ($urandom_range(0, 2) != 0);
         req_write = 1'($urandom);
         req_addr = ($urandom & 32'hFFFF_C00F) | 32'($urandom_range(0, 7) * 16);
         req_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clock);
      reset = 1'b0; req_valid = 1'b0;
      wait_idle();
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
